key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 18 +
 rtl/key_debounce.sv | 136 +++++++++++++
 2 files changed

// File: rtl/key_debounce_if.sv
// Key signal bundle: raw mechanical key in, debounced level and long-press pulse out.
interface key_debounce_if;
    logic key_raw;
    logic key_out;
    logic long_press;

    modport master (
        output key_raw,
        input  key_out,
        input  long_press
    );

    modport slave (
        input  key_raw,
        output key_out,
        output long_press
    );
endinterface

// File: rtl/key_debounce.sv
// Mechanical key debouncer: 2-flop synchronizer feeding a 4-state debounce FSM.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press counter and pulse.
module key_debounce #(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned CNT_W       = 20,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned LONG_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    key_debounce_if.slave    bus,
    output logic [1:0]       o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_cnt
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key_out;

    // Synchronizer idles at the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= bus.key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ ACTIVE_LOW;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned    LW        = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] r_long_cnt;
    logic          r_long_done;
    logic          r_long_press;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_key_out <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            r_long_cnt   <= '0;
            r_long_done  <= 1'b0;
            r_long_press <= 1'b0;
`endif
        end else begin
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            // Hold time keeps counting through a release bounce; done flag limits one pulse per press.
            r_long_press <= 1'b0;
            if (r_state == ST_PRESSED || r_state == ST_RELEASE_WAIT) begin
                if (r_long_cnt != LONG_LAST) begin
                    r_long_cnt <= r_long_cnt + LW'(1);
                end else if (!r_long_done) begin
                    r_long_press <= 1'b1;
                    r_long_done  <= 1'b1;
                end
            end
`endif
            case (r_state)
                ST_RELEASED: begin
                    if (w_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= ST_PRESSED;
                        r_cnt     <= '0;
                        r_key_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= ST_RELEASED;
                        r_cnt     <= '0;
                        r_key_out <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                        r_long_cnt  <= '0;
                        r_long_done <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.key_out = r_key_out;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    assign bus.long_press = r_long_press;
`else
    assign bus.long_press = 1'b0;
`endif

    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule
